// File: rtl/bcd_glyph_streamer.sv
// Renders a latched BCD count into a full SSD1306 frame and streams it one column byte at a time.
// One sync strobe homes the driver, then PAGES*COLS data bytes follow in horizontal-addressing order.
module bcd_glyph_streamer #(
  parameter int DIGITS_NUM = 6,
  parameter int COLS       = 128,
  parameter int PAGES      = 8,
  parameter int TEXT_PAGE  = 3
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [4*DIGITS_NUM-1:0] digits_in,
  input  logic [2:0]              dec_point_position_in,
  input  logic                    refresh_stb_in,
  output logic                    ready_out,
  output logic [7:0]              oled_data_out,
  output logic                    oled_write_stb_out,
  output logic                    oled_sync_stb_out,
  input  logic                    oled_ready_in
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CELLW = $clog2(COLS / 6 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SYNC_WAIT,
    S_DATA_WAIT,
    S_DATA
  } state_t;

  state_t                  r_state;
  logic [4*DIGITS_NUM-1:0] r_digits;
  logic [2:0]              r_p;
  logic [PW-1:0]           r_page;
  logic [CW-1:0]           r_col;
  logic [CELLW-1:0]        r_cell;
  logic [2:0]              r_fcol;
  logic                    r_first;
  logic                    r_ready;
  logic [7:0]              r_data;
  logic                    r_wr;
  logic                    r_sync;

  logic                    w_point;
  logic [2:0]              w_peff;
  logic [DIGITS_NUM-1:0]   w_blank;
  logic [7:0]              w_glyph;
  logic [7:0]              w_byte;
  logic                    w_last_col;
  logic                    w_last_page;

  function automatic logic [7:0] font_col(input logic [3:0] nib, input logic dot,
                                          input logic [2:0] fc);
    logic [39:0] pat;
    if (dot) begin
      pat = 40'h00_60_60_00_00;
    end else begin
      case (nib)
        4'd0:    pat = 40'h3E_51_49_45_3E;
        4'd1:    pat = 40'h00_42_7F_40_00;
        4'd2:    pat = 40'h42_61_51_49_46;
        4'd3:    pat = 40'h21_41_45_4B_31;
        4'd4:    pat = 40'h18_14_12_7F_10;
        4'd5:    pat = 40'h27_45_45_45_39;
        4'd6:    pat = 40'h3C_4A_49_49_30;
        4'd7:    pat = 40'h01_71_09_05_03;
        4'd8:    pat = 40'h36_49_49_49_36;
        4'd9:    pat = 40'h06_49_49_29_1E;
        default: pat = 40'h08_08_08_08_08;
      endcase
    end
    case (fc)
      3'd0:    return pat[39:32];
      3'd1:    return pat[31:24];
      3'd2:    return pat[23:16];
      3'd3:    return pat[15:8];
      3'd4:    return pat[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign w_point     = (r_p != 3'd0) && (int'(r_p) < DIGITS_NUM);
  assign w_peff      = w_point ? r_p : 3'd0;
  assign w_last_col  = (int'(r_col) == COLS - 1);
  assign w_last_page = (int'(r_page) == PAGES - 1);
  assign w_byte      = (int'(r_page) == TEXT_PAGE) ? w_glyph : 8'h00;

  // Leading zeros above the point position are blanked until the first non-zero digit.
  always_comb begin : blanking
    logic lead;
    lead    = 1'b1;
    w_blank = '0;
    for (int i = DIGITS_NUM - 1; i >= 0; i--) begin
      if (lead && (r_digits[4*i +: 4] == 4'd0) && (i > int'(w_peff))) begin
        w_blank[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // Cells run digit DIGITS_NUM-1 .. digit P, then '.', then digit P-1 .. digit 0.
  always_comb begin : cell_decode
    int         c;
    int         dcell;
    int         idx;
    logic [3:0] nib;
    logic       blk;
    c       = int'(r_cell);
    dcell   = DIGITS_NUM - int'(r_p);
    idx     = -1;
    nib     = 4'd0;
    blk     = 1'b0;
    w_glyph = 8'h00;
    if (w_point && (c > dcell) && (c <= DIGITS_NUM)) begin
      idx = DIGITS_NUM - c;
    end else if (c < (w_point ? dcell : DIGITS_NUM)) begin
      idx = DIGITS_NUM - 1 - c;
    end
    for (int i = 0; i < DIGITS_NUM; i++) begin
      if (i == idx) begin
        nib = r_digits[4*i +: 4];
        blk = w_blank[i];
      end
    end
    if (w_point && (c == dcell)) begin
      w_glyph = font_col(4'd0, 1'b1, r_fcol);
    end else if ((idx >= 0) && !blk) begin
      w_glyph = font_col(nib, 1'b0, r_fcol);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_p      <= '0;
      r_page   <= '0;
      r_col    <= '0;
      r_cell   <= '0;
      r_fcol   <= '0;
      r_first  <= 1'b0;
      r_ready  <= 1'b1;
      r_data   <= 8'h00;
      r_wr     <= 1'b0;
      r_sync   <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_sync <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (refresh_stb_in) begin
            r_digits <= digits_in;
            r_p      <= dec_point_position_in;
            r_page   <= '0;
            r_col    <= '0;
            r_cell   <= '0;
            r_fcol   <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (oled_ready_in) begin
            r_sync  <= 1'b1;
            r_first <= 1'b1;
            r_state <= S_SYNC_WAIT;
          end
        end
        // The driver drops ready only on the cycle after a strobe, so that cycle is skipped.
        S_SYNC_WAIT, S_DATA_WAIT: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (oled_ready_in) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (oled_ready_in) begin
            r_data <= w_byte;
            r_wr   <= 1'b1;
            if (w_last_col && w_last_page) begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              if (w_last_col) begin
                r_col  <= '0;
                r_cell <= '0;
                r_fcol <= '0;
                r_page <= r_page + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
                if (r_fcol == 3'd5) begin
                  r_fcol <= '0;
                  r_cell <= r_cell + 1'b1;
                end else begin
                  r_fcol <= r_fcol + 1'b1;
                end
              end
              r_first <= 1'b1;
              r_state <= S_DATA_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_out          = r_ready;
  assign oled_data_out      = r_data;
  assign oled_write_stb_out = r_wr;
  assign oled_sync_stb_out  = r_sync;

endmodule

// File: tb/tb_bcd_glyph_streamer.sv
// Directed bench for bcd_glyph_streamer: a golden frame model fills a byte queue on each accepted
// refresh, and every write strobe pops and compares one byte.
module tb_bcd_glyph_streamer;

  localparam int D         = 6;
  localparam int COLS      = 128;
  localparam int PAGES     = 8;
  localparam int TEXT_PAGE = 3;
  localparam int FRAME     = COLS * PAGES;
  localparam int BUDGET    = 8000;

  logic        clk_in         = 1'b0;
  logic        reset_in       = 1'b0;
  logic [23:0] digits_in      = '0;
  logic [2:0]  dp_in          = '0;
  logic        refresh_stb_in = 1'b0;
  logic        oled_ready_in  = 1'b1;
  logic        ready_out;
  logic [7:0]  oled_data_out;
  logic        oled_write_stb_out;
  logic        oled_sync_stb_out;

  int          n_asserts     = 0;
  int          n_fail        = 0;
  int          frame_writes  = 0;
  int          frame_syncs   = 0;
  int          strobes_total = 0;
  logic [7:0]  exp_q[$];
  logic        sync_expected = 1'b0;
  logic        prev_stb      = 1'b0;
  logic        rdy_edge      = 1'b1;
  logic        hold          = 1'b0;
  logic        rand_bp       = 1'b0;

  bcd_glyph_streamer #(
    .DIGITS_NUM(D),
    .COLS      (COLS),
    .PAGES     (PAGES),
    .TEXT_PAGE (TEXT_PAGE)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .digits_in            (digits_in),
    .dec_point_position_in(dp_in),
    .refresh_stb_in       (refresh_stb_in),
    .ready_out            (ready_out),
    .oled_data_out        (oled_data_out),
    .oled_write_stb_out   (oled_write_stb_out),
    .oled_sync_stb_out    (oled_sync_stb_out),
    .oled_ready_in        (oled_ready_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Glyph codes: 0..9 digits, 10 dash, 11 dot, 12 blank.
  function automatic logic [7:0] glyph(input int code, input int fc);
    logic [39:0] p;
    case (code)
      0:  p = 40'h3E5149453E;
      1:  p = 40'h00427F4000;
      2:  p = 40'h4261514946;
      3:  p = 40'h2141454B31;
      4:  p = 40'h1814127F10;
      5:  p = 40'h2745454539;
      6:  p = 40'h3C4A494930;
      7:  p = 40'h0171090503;
      8:  p = 40'h3649494936;
      9:  p = 40'h064949291E;
      10: p = 40'h0808080808;
      11: p = 40'h0060600000;
      default: p = 40'h0;
    endcase
    return p[8*(4-fc) +: 8];
  endfunction

  task automatic push_frame(input logic [23:0] d, input logic [2:0] p);
    int         codes[$];
    logic [7:0] line[COLS];
    logic [3:0] nib;
    bit         point;
    bit         seen;
    int         peff;
    point = (p != 0) && (int'(p) < D);
    peff  = point ? int'(p) : 0;
    seen  = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      nib = d[4*i +: 4];
      if (nib != 0) seen = 1'b1;
      if (!seen && i > peff) codes.push_back(12);
      else codes.push_back(nib > 9 ? 10 : int'(nib));
      if (point && i == int'(p)) codes.push_back(11);
    end
    for (int c = 0; c < COLS; c++) begin
      if ((c / 6) < codes.size() && (c % 6) < 5) line[c] = glyph(codes[c / 6], c % 6);
      else line[c] = 8'h00;
    end
    for (int pg = 0; pg < PAGES; pg++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(pg == TEXT_PAGE ? line[c] : 8'h00);
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk_in);
    rdy_edge = oled_ready_in;
    @(negedge clk_in);
    if (oled_write_stb_out || oled_sync_stb_out) begin
      chk("strobe_needs_ready", rdy_edge, 1);
      chk("strobe_exclusive", oled_write_stb_out & oled_sync_stb_out, 0);
      chk("strobe_spacing", prev_stb, 0);
      strobes_total++;
    end
    prev_stb = oled_write_stb_out | oled_sync_stb_out;
    if (oled_sync_stb_out) begin
      chk("sync_expected", sync_expected, 1);
      sync_expected = 1'b0;
      frame_syncs++;
    end
    if (oled_write_stb_out) begin
      chk("sync_before_write", sync_expected, 0);
      n_asserts++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_write: observed write #%0d expected no write", frame_writes);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("byte_%0d", frame_writes), oled_data_out, e);
      end
      frame_writes++;
    end
    oled_ready_in = hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic reset_pulse();
    #2 reset_in = 1'b1;
    #1;
    chk("rst_ready", ready_out, 1);
    chk("rst_wr", oled_write_stb_out, 0);
    chk("rst_sync", oled_sync_stb_out, 0);
    chk("rst_data", oled_data_out, 8'h00);
    #1 reset_in = 1'b0;
    exp_q.delete();
    sync_expected = 1'b0;
    prev_stb      = 1'b0;
  endtask

  task automatic do_refresh(input logic [23:0] d, input logic [2:0] p);
    int k = 0;
    while (ready_out !== 1'b1 && k < BUDGET) begin tick(); k++; end
    chk("ready_before_refresh", ready_out, 1);
    push_frame(d, p);
    sync_expected  = 1'b1;
    frame_writes   = 0;
    frame_syncs    = 0;
    digits_in      = d;
    dp_in          = p;
    refresh_stb_in = 1'b1;
    tick();
    refresh_stb_in = 1'b0;
    digits_in      = 24'($urandom);
    dp_in          = 3'($urandom);
    chk("busy_after_accept", ready_out, 0);
  endtask

  task automatic wait_writes(input int n);
    int k = 0;
    while (frame_writes < n && k < BUDGET) begin tick(); k++; end
    chk($sformatf("reach_write_%0d", n), frame_writes >= n, 1);
  endtask

  task automatic wait_frame_end(input string tag);
    int k = 0;
    while (!(ready_out === 1'b1 && exp_q.size() == 0) && k < BUDGET) begin tick(); k++; end
    chk({tag, "_ready"}, ready_out, 1);
    chk({tag, "_writes"}, frame_writes, FRAME);
    chk({tag, "_syncs"}, frame_syncs, 1);
  endtask

  initial begin
    int snap;
    // Asynchronous reset with no clock edge involved
    reset_pulse();

    // Point at 3 with a leading zero: blank,1,2,.,3,4,5
    do_refresh(24'h012345, 3'd3);
    wait_frame_end("f_012345");

    // All zeros: only the units digit drawn; then a dash in the units position
    do_refresh(24'h000000, 3'd0);
    wait_frame_end("f_zero");
    do_refresh(24'h00000A, 3'd0);
    wait_frame_end("f_dash");

    // Long stall at write 300, then random backpressure to the end
    do_refresh(24'h0A0012, 3'd4);
    wait_writes(300);
    hold = 1'b1;
    oled_ready_in = 1'b0;
    snap = strobes_total;
    repeat (50) tick();
    chk("no_strobe_while_stalled", strobes_total, snap);
    hold = 1'b0;
    rand_bp = 1'b1;
    wait_frame_end("f_backpressure");

    // Refresh mid-frame must be ignored; point position past the digits means no point
    do_refresh(24'h000789, 3'd7);
    wait_writes(200);
    digits_in      = 24'h111111;
    dp_in          = 3'd1;
    refresh_stb_in = 1'b1;
    tick();
    refresh_stb_in = 1'b0;
    wait_frame_end("f_ignore_refresh");

    // Abort by reset at write 500, then a clean frame starting with sync
    rand_bp = 1'b0;
    do_refresh(24'h123456, 3'd6);
    wait_writes(500);
    reset_pulse();
    do_refresh(24'h400300, 3'd2);
    wait_frame_end("f_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
